bsg_skid_fifo_bypass: RTL and testbench



---
 rtl/bsg_skid_fifo_bypass.sv | 92 +++++++++
 tb/tb_bsg_skid_fifo_bypass.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_skid_fifo_bypass.sv
// bsg_skid_fifo_bypass
//
// Two-entry valid/ready buffer with a zero-latency bypass path. When nothing
// is stored, the producer's word flows combinationally to the consumer. When
// the consumer stalls, up to two words are absorbed. ready_o is a function of
// registered occupancy only, so it breaks the backpressure timing path from
// yumi_i back to the producer.
//
// Ports:
//   clk_i    - clock, all state updates on the rising edge
//   reset_i  - asynchronous, active-high reset (drops stored words)
//   v_i      - producer data valid
//   data_i   - producer data word
//   ready_o  - buffer can accept a word this cycle
//   v_o      - data_o holds a valid word
//   data_o   - word presented to the consumer
//   yumi_i   - consumer takes data_o this cycle (only legal when v_o=1)
//   count_o  - stored occupancy 0..2; a bypassing word is not counted

module bsg_skid_fifo_bypass #(
    parameter int unsigned width_p = 16
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic [1:0]         count_o
);

    logic [1:0]         count_q, count_d;
    logic               rptr_q;
    logic               wptr_q;
    logic [width_p-1:0] mem_q [2];

    logic not_empty;
    logic enq;
    logic deq_stored;
    logic bypass;
    logic write;

    assign not_empty = (count_q != 2'd0);

    // Outputs
    assign ready_o = (count_q != 2'd2);
    assign v_o     = not_empty | v_i;
    assign data_o  = not_empty ? mem_q[rptr_q] : data_i;
    assign count_o = count_q;

    // Events
    assign enq        = v_i & ready_o;
    assign deq_stored = yumi_i & not_empty;
    // With nothing stored, a yumi can only be taking the incoming word.
    assign bypass     = yumi_i & ~not_empty;
    assign write      = enq & ~bypass;

    always_comb begin
        count_d = count_q;
        unique case ({write, deq_stored})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q <= 2'd0;
            rptr_q  <= 1'b0;
            wptr_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            if (write) begin
                wptr_q <= ~wptr_q;
            end
            if (deq_stored) begin
                rptr_q <= ~rptr_q;
            end
        end
    end

    // Storage is deliberately not reset; count gates its visibility.
    always_ff @(posedge clk_i) begin
        if (write) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: tb/tb_bsg_skid_fifo_bypass.sv
module tb_bsg_skid_fifo_bypass;

    logic        clk;
    logic        reset_i;
    logic        v_i;
    logic [15:0] data_i;
    logic        ready_o;
    logic        v_o;
    logic [15:0] data_o;
    logic        yumi_i;
    logic [1:0]  count_o;

    int checks = 0;
    int errors = 0;

    bsg_skid_fifo_bypass #(.width_p(16)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .v_o     (v_o),
        .data_o  (data_o),
        .yumi_i  (yumi_i),
        .count_o (count_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Consumer must never take a word that is not offered.
    always @(negedge clk) begin
        if (!reset_i && yumi_i && !v_o) begin
            errors++;
            $display("FAIL protocol: yumi_i=1 while v_o=%0b", v_o);
        end
    end

    task automatic drive(input logic v, input logic [15:0] d, input logic y);
        v_i    = v;
        data_i = d;
        yumi_i = y;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_i = 1'b1;
        drive(1'b0, 16'h0000, 1'b0);
        checks++;
        if (count_o !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_o); end
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_o); end
        checks++;
        if (v_o !== 1'b0) begin errors++; $display("FAIL reset_v_idle: got %b want 0", v_o); end
        drive(1'b1, 16'h1234, 1'b0);
        checks++;
        if (v_o !== 1'b1 || data_o !== 16'h1234) begin
            errors++; $display("FAIL reset_passthru: got v=%b d=%h want v=1 d=1234", v_o, data_o);
        end
        drive(1'b0, 16'h0000, 1'b0);
        tick;
        reset_i = 1'b0;
        tick;
    endtask

    task automatic test_bypass;
        drive(1'b1, 16'hA5A5, 1'b1);
        checks++;
        if (v_o !== 1'b1 || data_o !== 16'hA5A5) begin
            errors++; $display("FAIL bypass_data: got v=%b d=%h want v=1 d=a5a5", v_o, data_o);
        end
        tick;
        drive(1'b0, 16'h0000, 1'b0);
        checks++;
        if (count_o !== 2'd0 || v_o !== 1'b0) begin
            errors++; $display("FAIL bypass_count: got cnt=%0d v=%b want cnt=0 v=0", count_o, v_o);
        end
    endtask

    task automatic test_fill;
        drive(1'b1, 16'h0001, 1'b0);
        tick;
        drive(1'b1, 16'h0002, 1'b0);
        tick;
        drive(1'b1, 16'h0003, 1'b0);
        checks++;
        if (count_o !== 2'd2 || ready_o !== 1'b0 || data_o !== 16'h0001) begin
            errors++;
            $display("FAIL fill_full: got cnt=%0d rdy=%b d=%h want cnt=2 rdy=0 d=0001",
                     count_o, ready_o, data_o);
        end
        tick;
        drive(1'b0, 16'h0000, 1'b0);
        checks++;
        if (count_o !== 2'd2 || data_o !== 16'h0001) begin
            errors++; $display("FAIL fill_reject: got cnt=%0d d=%h want cnt=2 d=0001", count_o, data_o);
        end
    endtask

    task automatic test_drain;
        drive(1'b0, 16'h0000, 1'b1);
        checks++;
        if (data_o !== 16'h0001) begin errors++; $display("FAIL drain_first: got %h want 0001", data_o); end
        tick;
        checks++;
        if (data_o !== 16'h0002 || count_o !== 2'd1) begin
            errors++; $display("FAIL drain_second: got d=%h cnt=%0d want d=0002 cnt=1", data_o, count_o);
        end
        tick;
        drive(1'b0, 16'h0000, 1'b0);
        checks++;
        if (v_o !== 1'b0 || count_o !== 2'd0) begin
            errors++; $display("FAIL drain_empty: got v=%b cnt=%0d want v=0 cnt=0", v_o, count_o);
        end
    endtask

    task automatic test_full_deq;
        drive(1'b1, 16'h0021, 1'b0);
        tick;
        drive(1'b1, 16'h0022, 1'b0);
        tick;
        drive(1'b1, 16'h0023, 1'b1);
        checks++;
        if (ready_o !== 1'b0 || data_o !== 16'h0021) begin
            errors++; $display("FAIL fulldeq_same: got rdy=%b d=%h want rdy=0 d=0021", ready_o, data_o);
        end
        tick;
        drive(1'b0, 16'h0000, 1'b0);
        checks++;
        if (count_o !== 2'd1 || ready_o !== 1'b1 || data_o !== 16'h0022) begin
            errors++;
            $display("FAIL fulldeq_next: got cnt=%0d rdy=%b d=%h want cnt=1 rdy=1 d=0022",
                     count_o, ready_o, data_o);
        end
        drive(1'b0, 16'h0000, 1'b1);
        tick;
        drive(1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_stream;
        drive(1'b1, 16'h0010, 1'b0);
        tick;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h0011 + 16'(i), 1'b1);
            checks++;
            if (data_o !== 16'h0010 + 16'(i) || count_o !== 2'd1) begin
                errors++;
                $display("FAIL stream_%0d: got d=%h cnt=%0d want d=%h cnt=1",
                         i, data_o, count_o, 16'h0010 + 16'(i));
            end
            tick;
        end
        drive(1'b0, 16'h0000, 1'b0);
        checks++;
        if (data_o !== 16'h0013 || count_o !== 2'd1) begin
            errors++; $display("FAIL stream_tail: got d=%h cnt=%0d want d=0013 cnt=1", data_o, count_o);
        end
        drive(1'b0, 16'h0000, 1'b1);
        tick;
        drive(1'b0, 16'h0000, 1'b0);
    endtask

    task automatic test_async_reset;
        drive(1'b1, 16'h0031, 1'b0);
        tick;
        drive(1'b1, 16'h0032, 1'b0);
        tick;
        drive(1'b0, 16'h0000, 1'b0);
        #2;
        reset_i = 1'b1;
        #1;
        checks++;
        if (count_o !== 2'd0 || ready_o !== 1'b1 || v_o !== 1'b0) begin
            errors++;
            $display("FAIL areset_now: got cnt=%0d rdy=%b v=%b want cnt=0 rdy=1 v=0",
                     count_o, ready_o, v_o);
        end
        v_i    = 1'b1;
        data_i = 16'h5555;
        #1;
        checks++;
        if (v_o !== 1'b1 || data_o !== 16'h5555) begin
            errors++; $display("FAIL areset_track: got v=%b d=%h want v=1 d=5555", v_o, data_o);
        end
        v_i = 1'b0;
        #1;
        reset_i = 1'b0;
        tick;
        drive(1'b0, 16'h0000, 1'b0);
        checks++;
        if (v_o !== 1'b0 || count_o !== 2'd0) begin
            errors++; $display("FAIL areset_after: got v=%b cnt=%0d want v=0 cnt=0", v_o, count_o);
        end
        drive(1'b1, 16'h0077, 1'b1);
        checks++;
        if (data_o !== 16'h0077) begin errors++; $display("FAIL areset_stale: got %h want 0077", data_o); end
        tick;
        drive(1'b0, 16'h0000, 1'b0);
    endtask

    // Reference model: a queue of stored words, capacity two.
    task automatic test_random;
        logic [15:0] q[$];
        logic        v;
        logic        y;
        logic [15:0] d;
        logic        exp_v;
        int          n;
        q = {};
        for (int cyc = 0; cyc < 600; cyc++) begin
            n     = q.size();
            v     = ($urandom_range(0, 3) != 0);
            d     = 16'($urandom);
            exp_v = (n != 0) || v;
            y     = exp_v && ($urandom_range(0, 2) != 0);
            drive(v, d, y);
            checks++;
            if (ready_o !== (n != 2) || v_o !== exp_v || count_o !== 2'(n)) begin
                errors++;
                $display("FAIL rand_ctl@%0d: got rdy=%b v=%b cnt=%0d want rdy=%b v=%b cnt=%0d",
                         cyc, ready_o, v_o, count_o, (n != 2), exp_v, n);
            end
            if (exp_v) begin
                checks++;
                if (data_o !== ((n != 0) ? q[0] : d)) begin
                    errors++;
                    $display("FAIL rand_data@%0d: got %h want %h", cyc, data_o,
                             (n != 0) ? q[0] : d);
                end
            end
            tick;
            if (y && n != 0) void'(q.pop_front());
            if (v && n != 2 && !(y && n == 0)) q.push_back(d);
        end
        drive(1'b0, 16'h0000, 1'b0);
    endtask

    initial begin
        reset_i = 1'b1;
        v_i     = 1'b0;
        data_i  = '0;
        yumi_i  = 1'b0;
        test_reset;
        test_bypass;
        test_fill;
        test_drain;
        test_full_deq;
        test_stream;
        test_async_reset;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
